xalu_seq_ctrl: RTL and testbench
================================

Name: xalu_seq_ctrl

Overview:
- Sequencing controller for the execute-stage multiply/divide resource.
- Accepts one HI/LO operation at a time from the execute stage: MULT, MULTU, DIV, DIVU, MTHI, MTLO.
- Runs the multi-cycle multiply wait or iterative divide, owns the HI/LO registers and reports busy for pipeline stalls.
- Aborts in-flight work on exception flush without disturbing architectural HI/LO.

Parameters:
- MUL_LAT, 3, cycles from accepted multiply to HI/LO commit (≥1).
- DIV_BITS, 32, operand width and divider iteration count.

Ports:
- Clk  in  1  clock, rising edge.
- Clr_n  in  1  asynchronous active-low reset.
- start  in  1  op request, sampled only when busy==0.
- op  in  3  operation code (package enum).
- opa  in  32  rs operand, already forwarded.
- opb  in  32  rt operand, already forwarded.
- cancel  in  1  exception flush: abort in-flight op, drop same-cycle start.
- busy  out  1  op in flight (registered).
- done  out  1  one-cycle pulse on HI/LO commit.
- hi  out  32  architectural HI.
- lo  out  32  architectural LO.

Behaviour:
- Reset (Clr_n=0, async): state=IDLE, hi=0, lo=0, busy=0, done=0, counter=0, datapath regs=0.
- States: IDLE, MUL, DIV, FIX.
- IDLE:
  - start&!cancel with MTHI/MTLO: write hi or lo from opa at that edge; done=1 next cycle; busy stays 0.
  - MULT/MULTU: latch the 64-bit signed/unsigned product into a staging register; cnt=MUL_LAT-1; go to MUL; busy=1.
  - DIV/DIVU: latch |opa|, |opb| (absolute values for DIV), sign_q=opa[31]^opb[31], sign_r=opa[31]; cnt=DIV_BITS-1; go to DIV; busy=1.
  - Illegal op codes are ignored.
- MUL: cnt decrements each cycle. At cnt==0: commit {hi,lo}=product, done=1, go to IDLE, busy=0 on the same edge. Multiply latency is MUL_LAT cycles from the start edge to the commit edge.
- DIV: restoring shift-subtract, one quotient bit per cycle, MSB first, 33-bit partial remainder. After DIV_BITS iterations go to FIX.
- FIX:
  - Apply signs: lo=sign_q?-q:q; hi=sign_r?-r:r.
  - done=1, go to IDLE.
  - Total divide latency: DIV_BITS+1 = 33 cycles start-to-commit.
- Divide by zero: lo=0xFFFFFFFF, hi=opa (unsigned and signed alike), after the normal 33 cycles.
- Signed overflow 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0. Falls out of the absolute-value path; must be verified.
- cancel, any state: next edge forces IDLE, busy=0, done=0; hi/lo unchanged; same-cycle start discarded. cancel has priority over a commit due on the same edge, so no commit occurs.
- start while busy==1: ignored. The execute stage must stall on busy and must hold mfhi/mflo while busy.
- hi/lo change only on the commit edge. Reading mfhi/mflo in the done cycle returns the new value.
- Width rules:
  - Multiply is a full 64-bit product: signed uses sign-extended 33-bit operands, unsigned uses zero-extended.
  - Negation is two's complement mod 2^32.

Decomposition:
- Package xalu_pkg:
  - op enum: XOP_MULT=1, XOP_MULTU=2, XOP_DIV=3, XOP_DIVU=4, XOP_MTHI=5, XOP_MTLO=6; 0 is no-op.
  - state enum.
  - DIV_BITS default.
- Sub-module xalu_div_iter: one-step restoring divider datapath (remainder/quotient shift-subtract registers, load/step enables). The FSM, counter and HI/LO stay in xalu_seq_ctrl.

Test Plan:
- MULT opa=0xFFFFFFFE(-2), opb=0x00000003 -> after 3 cycles done=1, hi=0xFFFFFFFF, lo=0xFFFFFFFA; MULTU same operands -> hi=0x00000002, lo=0xFFFFFFFA.
- DIV opa=0xFFFFFFF9(-7), opb=2 -> busy 33 cycles, lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIVU 7/2 -> lo=3, hi=1.
- DIV opa=0x80000000, opb=0xFFFFFFFF -> lo=0x80000000, hi=0; DIVU opa=0x1234, opb=0 -> lo=0xFFFFFFFF, hi=0x1234.
- DIV started with hi=0xAAAA, lo=0x5555, cancel at cycle 10 -> busy=0 next cycle, done never pulses, hi/lo unchanged; cancel+start same cycle -> nothing accepted.
- MTHI 0xDEADBEEF then MTLO 0x0BADF00D on consecutive cycles -> hi/lo updated the edge after each; start during a divide -> ignored, the divide result is intact.
- Clr_n low mid-divide (async, between edges) -> busy, done, hi, lo read 0 immediately; after release the first op completes normally.

Source files
------------

// File: rtl/xalu_pkg.sv
// Shared types for the execute-stage HI/LO multiply/divide sequencer.
// Op codes match the execute-stage decode; 0 is a no-op.
package xalu_pkg;

    localparam int XLEN         = 32;
    localparam int DIV_BITS_DEF = 32;

    typedef enum logic [2:0] {
        XOP_NOP   = 3'd0,
        XOP_MULT  = 3'd1,
        XOP_MULTU = 3'd2,
        XOP_DIV   = 3'd3,
        XOP_DIVU  = 3'd4,
        XOP_MTHI  = 3'd5,
        XOP_MTLO  = 3'd6
    } xop_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_FIX  = 2'd3
    } xstate_e;

endpackage

// File: rtl/xalu_seq_ctrl_if.sv
// Request/result bundle between the execute stage and the HI/LO sequencer.
// The execute stage is the master; the sequencer is the slave.
interface xalu_seq_ctrl_if;
    import xalu_pkg::*;

    logic        start;
    xop_e        op;
    logic [31:0] opa;
    logic [31:0] opb;
    logic        cancel;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    modport master (
        output start, op, opa, opb, cancel,
        input  busy, done, hi, lo
    );

    modport slave (
        input  start, op, opa, opb, cancel,
        output busy, done, hi, lo
    );

endinterface

// File: rtl/xalu_div_iter.sv
// Restoring divider datapath: one quotient bit per step, MSB first.
// Operands are unsigned magnitudes; sign fix-up happens in the sequencer.
module xalu_div_iter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic         step,
    input  logic [W-1:0] dividend,
    input  logic [W-1:0] divisor,
    output logic [W-1:0] quo,
    output logic [W-1:0] rem
);
    logic [W-1:0] r;
    logic [W-1:0] q;
    logic [W-1:0] d;
    logic [W:0]   sh;
    logic [W:0]   diff;

    // The remainder stays below the divisor, so the trial fits W+1 bits.
    always_comb begin
        sh   = {r, q[W-1]};
        diff = sh - {1'b0, d};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r <= '0;
            q <= '0;
            d <= '0;
        end else if (load) begin
            r <= '0;
            q <= dividend;
            d <= divisor;
        end else if (step) begin
            if (!diff[W]) begin
                r <= diff[W-1:0];
                q <= {q[W-2:0], 1'b1};
            end else begin
                r <= sh[W-1:0];
                q <= {q[W-2:0], 1'b0};
            end
        end
    end

    assign quo = q;
    assign rem = r;

endmodule

// File: rtl/xalu_seq_ctrl.sv
// Execute-stage HI/LO sequencer: multiply wait, iterative divide,
// MTHI/MTLO writes, busy for stalls and cancel on exception flush.
module xalu_seq_ctrl
    import xalu_pkg::*;
#(
    parameter int MUL_LAT  = 3,
    parameter int DIV_BITS = DIV_BITS_DEF
) (
    input  logic           Clk,
    input  logic           Clr_n,
    xalu_seq_ctrl_if.slave bus
);
    localparam int CMAX = (MUL_LAT > DIV_BITS) ? MUL_LAT : DIV_BITS;
    localparam int CW   = ($clog2(CMAX) > 0) ? $clog2(CMAX) : 1;

    xstate_e state, state_n;

    logic [CW-1:0]       cnt;
    logic [63:0]         prod;
    logic                sign_q;
    logic                sign_r;
    logic                dz;
    logic [31:0]         hi;
    logic [31:0]         lo;
    logic                done;

    logic                ld_mul;
    logic                ld_div;
    logic                mt_hi;
    logic                mt_lo;
    logic                div_step;
    logic                cm_mul;
    logic                cm_div;

    logic signed [32:0]  ma;
    logic signed [32:0]  mb;
    logic signed [63:0]  mp;
    logic                is_sdiv;
    logic [DIV_BITS-1:0] a_abs;
    logic [DIV_BITS-1:0] b_abs;
    logic [DIV_BITS-1:0] quo;
    logic [DIV_BITS-1:0] rem;

    always_comb begin
        ma      = {(bus.op == XOP_MULT) & bus.opa[31], bus.opa};
        mb      = {(bus.op == XOP_MULT) & bus.opb[31], bus.opb};
        mp      = 64'(ma) * 64'(mb);
        is_sdiv = (bus.op == XOP_DIV);
        a_abs   = (is_sdiv && bus.opa[31]) ? -bus.opa : bus.opa;
        b_abs   = (is_sdiv && bus.opb[31]) ? -bus.opb : bus.opb;
    end

    always_ff @(posedge Clk or negedge Clr_n) begin
        if (!Clr_n) state <= S_IDLE;
        else        state <= state_n;
    end

    // Cancel wins over everything, including a commit due this edge.
    always_comb begin
        state_n  = state;
        ld_mul   = 1'b0;
        ld_div   = 1'b0;
        mt_hi    = 1'b0;
        mt_lo    = 1'b0;
        div_step = 1'b0;
        cm_mul   = 1'b0;
        cm_div   = 1'b0;
        if (bus.cancel) begin
            state_n = S_IDLE;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (bus.start) begin
                        unique case (bus.op)
                            XOP_MULT, XOP_MULTU: begin
                                ld_mul  = 1'b1;
                                state_n = S_MUL;
                            end
                            XOP_DIV, XOP_DIVU: begin
                                ld_div  = 1'b1;
                                state_n = S_DIV;
                            end
                            XOP_MTHI: mt_hi = 1'b1;
                            XOP_MTLO: mt_lo = 1'b1;
                            default: ;
                        endcase
                    end
                end
                S_MUL: begin
                    if (cnt == '0) begin
                        cm_mul  = 1'b1;
                        state_n = S_IDLE;
                    end
                end
                S_DIV: begin
                    div_step = 1'b1;
                    if (cnt == '0) state_n = S_FIX;
                end
                S_FIX: begin
                    cm_div  = 1'b1;
                    state_n = S_IDLE;
                end
                default: state_n = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge Clk or negedge Clr_n) begin
        if (!Clr_n) begin
            cnt    <= '0;
            prod   <= '0;
            sign_q <= 1'b0;
            sign_r <= 1'b0;
            dz     <= 1'b0;
            hi     <= '0;
            lo     <= '0;
            done   <= 1'b0;
        end else begin
            done <= mt_hi | mt_lo | cm_mul | cm_div;
            if (ld_mul) begin
                prod <= mp;
                cnt  <= CW'(MUL_LAT - 1);
            end else if (ld_div) begin
                sign_q <= is_sdiv & (bus.opa[31] ^ bus.opb[31]);
                sign_r <= is_sdiv & bus.opa[31];
                dz     <= (bus.opb == '0);
                cnt    <= CW'(DIV_BITS - 1);
            end else if (cnt != '0 && (state == S_MUL || div_step)) begin
                cnt <= cnt - CW'(1);
            end
            if (mt_hi) hi <= bus.opa;
            if (mt_lo) lo <= bus.opa;
            if (cm_mul) begin
                hi <= prod[63:32];
                lo <= prod[31:0];
            end
            // Divide by zero keeps the raw all-ones quotient unsigned.
            if (cm_div) begin
                lo <= dz ? '1 : (sign_q ? -quo : quo);
                hi <= sign_r ? -rem : rem;
            end
        end
    end

    xalu_div_iter #(
        .W(DIV_BITS)
    ) u_div (
        .clk      (Clk),
        .rst_n    (Clr_n),
        .load     (ld_div),
        .step     (div_step),
        .dividend (a_abs),
        .divisor  (b_abs),
        .quo      (quo),
        .rem      (rem)
    );

    assign bus.busy = (state != S_IDLE);
    assign bus.done = done;
    assign bus.hi   = hi;
    assign bus.lo   = lo;

endmodule

// File: tb/tb_xalu_seq_ctrl.sv
// Bench for the HI/LO sequencer: directed cases plus a randomized
// op stream checked against a plain-arithmetic reference model.
module tb_xalu_seq_ctrl;
    import xalu_pkg::*;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    xalu_seq_ctrl_if bus ();

    xalu_seq_ctrl #(
        .MUL_LAT  (3),
        .DIV_BITS (32)
    ) dut (
        .Clk   (clk),
        .Clr_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void model(input xop_e o, input logic [31:0] a,
                                  input logic [31:0] b,
                                  inout logic [31:0] mh,
                                  inout logic [31:0] ml,
                                  output int lat);
        longint sa;
        longint sb;
        longint p;
        logic [63:0] u;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        lat = -1;
        case (o)
            XOP_MULT: begin
                p = sa * sb;
                mh = p[63:32]; ml = p[31:0]; lat = 3;
            end
            XOP_MULTU: begin
                u = {32'd0, a} * {32'd0, b};
                mh = u[63:32]; ml = u[31:0]; lat = 3;
            end
            XOP_DIV: begin
                if (b == 0) begin
                    ml = 32'hFFFF_FFFF; mh = a;
                end else begin
                    p = sa / sb; ml = p[31:0];
                    p = sa % sb; mh = p[31:0];
                end
                lat = 33;
            end
            XOP_DIVU: begin
                if (b == 0) begin
                    ml = 32'hFFFF_FFFF; mh = a;
                end else begin
                    ml = a / b; mh = a % b;
                end
                lat = 33;
            end
            XOP_MTHI: begin mh = a; lat = 0; end
            XOP_MTLO: begin ml = a; lat = 0; end
            default: lat = -1;
        endcase
    endfunction

    // Issue one op and count edges until done; returns busy after start.
    task automatic do_op(input xop_e o, input logic [31:0] a,
                         input logic [31:0] b, input int max,
                         output int lat, output logic b0);
        bus.op    = o;
        bus.opa   = a;
        bus.opb   = b;
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        b0  = bus.busy;
        lat = 0;
        while (bus.done !== 1'b1 && lat < max) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic test_reset();
        rst_n      = 1'b0;
        bus.start  = 1'b0;
        bus.cancel = 1'b0;
        bus.op     = XOP_NOP;
        bus.opa    = '0;
        bus.opb    = '0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({bus.busy, bus.done} !== 2'b00 || bus.hi !== 0 || bus.lo !== 0) begin
            errors++;
            $display("FAIL reset: busy=%b done=%b hi=%h lo=%h want 0",
                     bus.busy, bus.done, bus.hi, bus.lo);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_mul();
        int lat;
        logic b0;
        do_op(XOP_MULT, 32'hFFFF_FFFE, 32'h3, 100, lat, b0);
        checks++;
        if (lat != 3 || b0 !== 1'b1) begin
            errors++;
            $display("FAIL mult_lat: got lat=%0d busy=%b want 3/1", lat, b0);
        end
        checks++;
        if (bus.hi !== 32'hFFFF_FFFF || bus.lo !== 32'hFFFF_FFFA) begin
            errors++;
            $display("FAIL mult: got %h_%h want ffffffff_fffffffa", bus.hi, bus.lo);
        end
        do_op(XOP_MULTU, 32'hFFFF_FFFE, 32'h3, 100, lat, b0);
        checks++;
        if (lat != 3 || bus.hi !== 32'h2 || bus.lo !== 32'hFFFF_FFFA) begin
            errors++;
            $display("FAIL multu: got lat=%0d %h_%h want 3 00000002_fffffffa",
                     lat, bus.hi, bus.lo);
        end
    endtask

    task automatic test_div();
        int lat;
        logic b0;
        do_op(XOP_DIV, 32'hFFFF_FFF9, 32'h2, 100, lat, b0);
        checks++;
        if (lat != 33 || b0 !== 1'b1) begin
            errors++;
            $display("FAIL div_lat: got lat=%0d busy=%b want 33/1", lat, b0);
        end
        checks++;
        if (bus.lo !== 32'hFFFF_FFFD || bus.hi !== 32'hFFFF_FFFF) begin
            errors++;
            $display("FAIL div: got lo=%h hi=%h want fffffffd ffffffff", bus.lo, bus.hi);
        end
        do_op(XOP_DIVU, 32'h7, 32'h2, 100, lat, b0);
        checks++;
        if (lat != 33 || bus.lo !== 32'h3 || bus.hi !== 32'h1) begin
            errors++;
            $display("FAIL divu: got lat=%0d lo=%h hi=%h want 33 3 1", lat, bus.lo, bus.hi);
        end
    endtask

    task automatic test_div_edge();
        int lat;
        logic b0;
        do_op(XOP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 100, lat, b0);
        checks++;
        if (lat != 33 || bus.lo !== 32'h8000_0000 || bus.hi !== 32'h0) begin
            errors++;
            $display("FAIL div_ovf: got lat=%0d lo=%h hi=%h want 33 80000000 0",
                     lat, bus.lo, bus.hi);
        end
        do_op(XOP_DIVU, 32'h1234, 32'h0, 100, lat, b0);
        checks++;
        if (lat != 33 || bus.lo !== 32'hFFFF_FFFF || bus.hi !== 32'h1234) begin
            errors++;
            $display("FAIL divu_zero: got lat=%0d lo=%h hi=%h want 33 ffffffff 1234",
                     lat, bus.lo, bus.hi);
        end
        do_op(XOP_DIV, 32'hFFFF_FFF9, 32'h0, 100, lat, b0);
        checks++;
        if (lat != 33 || bus.lo !== 32'hFFFF_FFFF || bus.hi !== 32'hFFFF_FFF9) begin
            errors++;
            $display("FAIL div_zero: got lat=%0d lo=%h hi=%h want 33 ffffffff fffffff9",
                     lat, bus.lo, bus.hi);
        end
    endtask

    task automatic test_cancel();
        int lat;
        logic b0;
        logic seen;
        do_op(XOP_MTHI, 32'hAAAA, 32'h0, 100, lat, b0);
        do_op(XOP_MTLO, 32'h5555, 32'h0, 100, lat, b0);
        bus.op = XOP_DIV; bus.opa = 32'd100; bus.opb = 32'd3;
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (9) begin @(posedge clk); #1; end
        bus.cancel = 1'b1;
        @(posedge clk); #1;
        bus.cancel = 1'b0;
        checks++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            errors++;
            $display("FAIL cancel_busy: got busy=%b done=%b want 0 0", bus.busy, bus.done);
        end
        seen = 1'b0;
        repeat (40) begin @(posedge clk); #1; seen |= bus.done; end
        checks++;
        if (seen !== 1'b0 || bus.hi !== 32'hAAAA || bus.lo !== 32'h5555) begin
            errors++;
            $display("FAIL cancel_keep: got done_seen=%b hi=%h lo=%h want 0 aaaa 5555",
                     seen, bus.hi, bus.lo);
        end
        // Same-cycle start and cancel: neither multiply nor MTHI lands.
        bus.op = XOP_MULT; bus.opa = 32'd5; bus.opb = 32'd5;
        bus.start = 1'b1; bus.cancel = 1'b1;
        @(posedge clk); #1;
        bus.op = XOP_MTHI; bus.opa = 32'h1;
        @(posedge clk); #1;
        bus.start = 1'b0; bus.cancel = 1'b0;
        seen = bus.busy | bus.done;
        repeat (5) begin @(posedge clk); #1; seen |= bus.busy | bus.done; end
        checks++;
        if (seen !== 1'b0 || bus.hi !== 32'hAAAA || bus.lo !== 32'h5555) begin
            errors++;
            $display("FAIL cancel_start: got act=%b hi=%h lo=%h want 0 aaaa 5555",
                     seen, bus.hi, bus.lo);
        end
        // Cancel landing exactly on the multiply commit edge.
        bus.op = XOP_MULT; bus.opa = 32'd7; bus.opb = 32'd9;
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        bus.cancel = 1'b1;
        @(posedge clk); #1;
        bus.cancel = 1'b0;
        checks++;
        if (bus.done !== 1'b0 || bus.busy !== 1'b0 || bus.lo !== 32'h5555) begin
            errors++;
            $display("FAIL cancel_mcommit: got done=%b busy=%b lo=%h want 0 0 5555",
                     bus.done, bus.busy, bus.lo);
        end
        // Cancel landing on the divide sign-fix edge.
        bus.op = XOP_DIVU; bus.opa = 32'd50; bus.opb = 32'd7;
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (32) begin @(posedge clk); #1; end
        bus.cancel = 1'b1;
        @(posedge clk); #1;
        bus.cancel = 1'b0;
        checks++;
        if (bus.done !== 1'b0 || bus.busy !== 1'b0 ||
            bus.hi !== 32'hAAAA || bus.lo !== 32'h5555) begin
            errors++;
            $display("FAIL cancel_dcommit: got done=%b busy=%b hi=%h lo=%h want 0 0 aaaa 5555",
                     bus.done, bus.busy, bus.hi, bus.lo);
        end
    endtask

    task automatic test_back_to_back();
        int lat;
        bus.op = XOP_MTHI; bus.opa = 32'hDEAD_BEEF; bus.start = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (bus.hi !== 32'hDEAD_BEEF || bus.done !== 1'b1 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL mthi: got hi=%h done=%b busy=%b want deadbeef 1 0",
                     bus.hi, bus.done, bus.busy);
        end
        bus.op = XOP_MTLO; bus.opa = 32'h0BAD_F00D;
        @(posedge clk); #1;
        bus.start = 1'b0;
        checks++;
        if (bus.lo !== 32'h0BAD_F00D || bus.hi !== 32'hDEAD_BEEF || bus.done !== 1'b1) begin
            errors++;
            $display("FAIL mtlo: got hi=%h lo=%h done=%b want deadbeef 0badf00d 1",
                     bus.hi, bus.lo, bus.done);
        end
        // Starts issued while a divide is running must be dropped.
        bus.op = XOP_DIV; bus.opa = 32'hFFFF_FFF9; bus.opb = 32'd2;
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        lat = 0;
        repeat (5) begin @(posedge clk); #1; lat++; end
        bus.op = XOP_MTHI; bus.opa = 32'h1111; bus.start = 1'b1;
        @(posedge clk); #1;
        lat++;
        bus.op = XOP_MULT; bus.opa = 32'd3; bus.opb = 32'd3;
        @(posedge clk); #1;
        lat++;
        bus.start = 1'b0;
        checks++;
        if (bus.done !== 1'b0 || bus.hi !== 32'hDEAD_BEEF || bus.busy !== 1'b1) begin
            errors++;
            $display("FAIL busy_ignore: got done=%b hi=%h busy=%b want 0 deadbeef 1",
                     bus.done, bus.hi, bus.busy);
        end
        while (bus.done !== 1'b1 && lat < 100) begin @(posedge clk); #1; lat++; end
        checks++;
        if (lat != 33 || bus.lo !== 32'hFFFF_FFFD || bus.hi !== 32'hFFFF_FFFF) begin
            errors++;
            $display("FAIL busy_div: got lat=%0d lo=%h hi=%h want 33 fffffffd ffffffff",
                     lat, bus.lo, bus.hi);
        end
    endtask

    task automatic test_async_reset();
        int lat;
        logic b0;
        do_op(XOP_MTHI, 32'h7777, 32'h0, 100, lat, b0);
        bus.op = XOP_DIV; bus.opa = 32'd1000; bus.opb = 32'd7;
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (10) begin @(posedge clk); #1; end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({bus.busy, bus.done} !== 2'b00 || bus.hi !== 0 || bus.lo !== 0) begin
            errors++;
            $display("FAIL async_reset: busy=%b done=%b hi=%h lo=%h want 0",
                     bus.busy, bus.done, bus.hi, bus.lo);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        do_op(XOP_MULTU, 32'hFFFF_FFFE, 32'h3, 100, lat, b0);
        checks++;
        if (lat != 3 || bus.hi !== 32'h2 || bus.lo !== 32'hFFFF_FFFA) begin
            errors++;
            $display("FAIL post_reset: got lat=%0d %h_%h want 3 00000002_fffffffa",
                     lat, bus.hi, bus.lo);
        end
    endtask

    function automatic logic [31:0] rand_opnd();
        case ($urandom_range(0, 5))
            0: return 32'h0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'($urandom_range(0, 20));
            default: return 32'($urandom);
        endcase
    endfunction

    task automatic test_random();
        logic [31:0] mh;
        logic [31:0] ml;
        logic [31:0] a;
        logic [31:0] b;
        xop_e o;
        int exp_lat;
        int lat;
        logic b0;
        mh = bus.hi;
        ml = bus.lo;
        for (int i = 0; i < 40; i++) begin
            o = xop_e'(3'($urandom_range(0, 7)));
            a = rand_opnd();
            b = rand_opnd();
            model(o, a, b, mh, ml, exp_lat);
            if (exp_lat < 0) begin
                do_op(o, a, b, 4, lat, b0);
                checks++;
                if (lat != 4 || b0 !== 1'b0 || bus.hi !== mh || bus.lo !== ml) begin
                    errors++;
                    $display("FAIL rand_illegal[%0d]: op=%0d lat=%0d busy=%b hi=%h lo=%h want no-op %h %h",
                             i, o, lat, b0, bus.hi, bus.lo, mh, ml);
                end
            end else begin
                do_op(o, a, b, 100, lat, b0);
                checks++;
                if (lat != exp_lat || b0 !== (exp_lat > 0)) begin
                    errors++;
                    $display("FAIL rand_lat[%0d]: op=%0d got lat=%0d busy=%b want %0d",
                             i, o, lat, b0, exp_lat);
                end
                checks++;
                if (bus.hi !== mh || bus.lo !== ml) begin
                    errors++;
                    $display("FAIL rand_val[%0d]: op=%0d a=%h b=%h got %h_%h want %h_%h",
                             i, o, a, b, bus.hi, bus.lo, mh, ml);
                end
            end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_mul();
        test_div();
        test_div_edge();
        test_cancel();
        test_back_to_back();
        test_async_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
